gen_ram_2p: RTL

- Parametrised simple dual-port RAM: one write port and one read port, sharing one clock.
- Successor to the single-port byte-masked generic RAM.
- Adds independent concurrent read/write, a read request/valid/ready handshake with backpressure, optional output pipeline register, and read-during-write bypass.
- Out-of-range accesses are flagged.
- Used as core scratchpad / data RAM and as FIFO storage in bus bridges.

---
 rtl/gen_ram_pkg.sv | 27 ++
 rtl/gen_ram_bmerge.sv | 17 +
 rtl/gen_ram_2p.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gen_ram_pkg.sv
// Shared helpers for the generic RAM family (single-port and dual-port).
//   clog2_lanes : number of byte lanes needed to cover a data width
//   lane_mask   : expand per-lane enables into a per-bit mask
package gen_ram_pkg;

  // Upper bound on supported data width; functions work on this fixed width and
  // callers cast the result down to their own DW.
  localparam int unsigned MAX_DW    = 1024;
  localparam int unsigned MAX_LANES = MAX_DW / 8;

  function automatic int unsigned clog2_lanes(input int unsigned dw);
    return (dw + 7) / 8;
  endfunction

  // Bit i belongs to lane i/8; bits at or above dw stay clear, so a partial top
  // lane only covers the bits that exist.
  function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_LANES-1:0] sel,
                                                  input int unsigned dw);
    logic [MAX_DW-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      if (i < dw) mask[i[9:0]] = sel[i[9:3]];
    end
    return mask;
  endfunction

endpackage

// File: rtl/gen_ram_bmerge.sv
// Byte-merge: replaces the masked bits of an old word with new data.
//   old_i    : existing word
//   new_i    : incoming data
//   mask_i   : per-bit select, 1 = take new_i
//   merged_o : combined word
module gen_ram_bmerge #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] old_i,
  input  logic [DW-1:0] new_i,
  input  logic [DW-1:0] mask_i,
  output logic [DW-1:0] merged_o
);

  assign merged_o = (old_i & ~mask_i) | (new_i & mask_i);

endmodule

// File: rtl/gen_ram_2p.sv
// Simple dual-port RAM: one byte-masked write port, one read port with a
// request/grant and valid/ready handshake, shared clock.
//   clk, rst_n        : clock, asynchronous active-low reset
//   w_req_i .. w_sel_i: write strobe, word address, data, byte-lane enables
//   r_req_i, r_addr_i : read request and word address
//   r_gnt_o           : read request accepted this cycle
//   r_rvalid_o        : read data valid, held until r_ready_i
//   r_data_o, r_err_o : read data; err flags an address >= DP (data is then 0)
module gen_ram_2p
  import gen_ram_pkg::*;
#(
  parameter int unsigned DP      = 512,
  parameter int unsigned DW      = 32,
  parameter int unsigned MW      = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned OUT_REG = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_req_i,
  input  logic [AW-1:0] w_addr_i,
  input  logic [DW-1:0] w_data_i,
  input  logic [MW-1:0] w_sel_i,
  input  logic          r_req_i,
  input  logic [AW-1:0] r_addr_i,
  output logic          r_gnt_o,
  output logic          r_rvalid_o,
  input  logic          r_ready_i,
  output logic [DW-1:0] r_data_o,
  output logic          r_err_o
);

  localparam int unsigned IW = (DP > 1) ? $clog2(DP) : 1;

  if (MW != clog2_lanes(DW)) begin : g_bad_mw
    $error("gen_ram_2p: MW must equal ceil(DW/8)");
  end
  if (DW > MAX_DW) begin : g_bad_dw
    $error("gen_ram_2p: DW exceeds gen_ram_pkg::MAX_DW");
  end

  logic [DW-1:0] r_mem [DP];

  // Write path
  logic [MAX_LANES-1:0] w_sel_ext;
  logic [DW-1:0]        w_mask;
  logic [IW-1:0]        w_widx;
  logic                 w_w_in;
  logic                 w_we;
  logic [DW-1:0]        w_wr_old;
  logic [DW-1:0]        w_wr_merged;

  always_comb begin
    w_sel_ext            = '0;
    w_sel_ext[MW-1:0]    = w_sel_i;
    w_mask               = DW'(lane_mask(w_sel_ext, DW));
  end

  assign w_widx   = w_addr_i[IW-1:0];
  assign w_w_in   = (w_addr_i < AW'(DP));
  assign w_we     = w_req_i & w_w_in;
  assign w_wr_old = r_mem[w_widx];

  gen_ram_bmerge #(.DW(DW)) u_wr_merge (
    .old_i    (w_wr_old),
    .new_i    (w_data_i),
    .mask_i   (w_mask),
    .merged_o (w_wr_merged)
  );

  // Contents are not reset; the reset branch only blocks writes while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (w_we) begin
      r_mem[w_widx] <= w_wr_merged;
    end
  end

  // Read stage 1
  logic          w_accept;
  logic          w_stall;
  logic          w_s1_free;
  logic [IW-1:0] w_ridx;
  logic          w_r_in;
  logic          w_hit;
  logic [DW-1:0] w_rd_old;
  logic [DW-1:0] w_byp_data;
  logic [DW-1:0] w_s1_next;
  logic          r_s1_valid;
  logic          r_s1_err;
  logic [DW-1:0] r_s1_data;

  assign w_accept = r_req_i & r_gnt_o;
  assign w_ridx   = r_addr_i[IW-1:0];
  assign w_r_in   = (r_addr_i < AW'(DP));
  assign w_rd_old = r_mem[w_ridx];
  assign w_hit    = (BYPASS != 0) && w_we && (w_addr_i == r_addr_i);

  gen_ram_bmerge #(.DW(DW)) u_byp_merge (
    .old_i    (w_rd_old),
    .new_i    (w_data_i),
    .mask_i   (w_mask),
    .merged_o (w_byp_data)
  );

  always_comb begin
    w_s1_next = '0;
    if (w_r_in) w_s1_next = w_hit ? w_byp_data : w_rd_old;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_err   <= ~w_r_in;
      r_s1_data  <= w_s1_next;
    end else if (w_s1_free) begin
      // Data is left in place so r_data_o keeps its last value after a drain.
      r_s1_valid <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          r_s2_valid;
    logic          r_s2_err;
    logic [DW-1:0] r_s2_data;

    assign w_stall   = r_s2_valid & ~r_ready_i;
    // Stage 1 may still take a request while stage 2 is stalled, as long as it is empty.
    assign r_gnt_o   = ~(r_s1_valid & w_stall);
    assign w_s1_free = ~w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_valid <= 1'b0;
        r_s2_err   <= 1'b0;
        r_s2_data  <= '0;
      end else if (!w_stall) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_err  <= r_s1_err;
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign r_rvalid_o = r_s2_valid;
    assign r_data_o   = r_s2_data;
    assign r_err_o    = r_s2_err;
  end else begin : g_no_out_reg
    assign w_stall    = r_s1_valid & ~r_ready_i;
    assign r_gnt_o    = ~w_stall;
    assign w_s1_free  = ~w_stall;
    assign r_rvalid_o = r_s1_valid;
    assign r_data_o   = r_s1_data;
    assign r_err_o    = r_s1_err;
  end

endmodule
